// File: rtl/fs_8bits_serial.sv
// Bit-serial 8-bit subtractor: diff = i0 - i1 - bin, one bit per clock, LSB first.
// Optional signed overflow output built when FS_8BITS_SERIAL_OVF_EN is defined.
module fs_8bits_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] i0,
  input  logic [7:0] i1,
  input  logic       bin,
  output logic       busy,
  output logic       done,
  output logic [7:0] diff,
  output logic       bout,
  output logic       ovf
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       br_q, br_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] part_q, part_d;
  logic [7:0] diff_q, diff_d;
  logic       bout_q, bout_d;
`ifdef FS_8BITS_SERIAL_OVF_EN
  logic       ovf_q, ovf_d;
`endif

  logic ak, bk, d_bit, br_nxt;

  assign ak     = a_q[cnt_q];
  assign bk     = b_q[cnt_q];
  assign d_bit  = ak ^ bk ^ br_q;
  assign br_nxt = (~ak & bk) | (~(ak ^ bk) & br_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef FS_8BITS_SERIAL_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        // DONE accepts start exactly like IDLE so operations can run back to back
        if (start) begin
          a_d     = i0;
          b_d     = i1;
          br_d    = bin;
          cnt_d   = 3'd0;
          part_d  = 8'h00;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        br_d   = br_nxt;
        part_d = {d_bit, part_q[7:1]};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = StDone;
          diff_d  = {d_bit, part_q[7:1]};
          bout_d  = br_nxt;
`ifdef FS_8BITS_SERIAL_OVF_EN
          ovf_d   = (a_q[7] != b_q[7]) & (d_bit != a_q[7]);
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      br_q    <= 1'b0;
      cnt_q   <= 3'd0;
      part_q  <= 8'h00;
      diff_q  <= 8'h00;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

`ifdef FS_8BITS_SERIAL_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_fs_8bits_serial.sv
// Self-checking bench for fs_8bits_serial: directed cases plus random back-to-back
// operations compared against an integer-arithmetic reference model.
module tb_fs_8bits_serial;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] i0;
  logic [7:0] i1;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  fs_8bits_serial dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .i0   (i0),
    .i1   (i1),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic c,
                                output logic [7:0] d, output logic bo, output logic ov);
    int r;
    int s;
    r  = int'(a) - int'(b) - int'(c);
    s  = int'($signed(a)) - int'($signed(b)) - int'(c);
    d  = r[7:0];
    bo = (r < 0);
`ifdef FS_8BITS_SERIAL_OVF_EN
    ov = (s < -128) || (s > 127);
`else
    ov = 1'b0;
`endif
  endfunction

  // Called at a falling edge; returns at the falling edge just after the accepting edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c);
    i0    = a;
    i1    = b;
    bin   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; lat = falling edges waited, -1 on timeout.
  task automatic wait_done(output int lat, output int busy_cnt, output logic moved);
    logic [7:0] d0;
    d0       = diff;
    busy_cnt = busy ? 1 : 0;
    moved    = 1'b0;
    lat      = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_cnt++;
      if (diff !== d0) moved = 1'b1;
    end
  endtask

  task automatic test_reset;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff got=%h exp=00", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout got=%b exp=0", bout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_directed;
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic [7:0] ed;
    logic       eb, eo, moved;
    int         lat, bc;
    ta[0] = 8'h50; tb[0] = 8'h20;
    ta[1] = 8'h00; tb[1] = 8'h01;
    ta[2] = 8'h80; tb[2] = 8'h01;
    for (int t = 0; t < 3; t++) begin
      model(ta[t], tb[t], 1'b0, ed, eb, eo);
      start_op(ta[t], tb[t], 1'b0);
      wait_done(lat, bc, moved);
      checks++; if (lat !== 8) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=8", t, lat); end
      checks++; if (bc !== 8) begin errors++; $display("FAIL dir%0d_busy_cycles got=%0d exp=8", t, bc); end
      checks++; if (diff !== ed) begin errors++; $display("FAIL dir%0d_diff got=%h exp=%h", t, diff, ed); end
      checks++; if (bout !== eb) begin errors++; $display("FAIL dir%0d_bout got=%b exp=%b", t, bout, eb); end
      checks++; if (ovf !== eo) begin errors++; $display("FAIL dir%0d_ovf got=%b exp=%b", t, ovf, eo); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got=%b exp=0", t, done); end
      checks++; if (diff !== ed) begin errors++; $display("FAIL dir%0d_hold got=%h exp=%h", t, diff, ed); end
    end
  endtask

  task automatic test_borrow_in;
    int   lat, bc;
    logic moved;
    start_op(8'h10, 8'h10, 1'b1);
    @(negedge clk);
    i0  = 8'hAA;
    bin = 1'b0;
    wait_done(lat, bc, moved);
    checks++; if (lat !== 7) begin errors++; $display("FAIL bin_latency got=%0d exp=7", lat); end
    checks++; if (diff !== 8'hFF) begin errors++; $display("FAIL bin_diff got=%h exp=ff", diff); end
    checks++; if (bout !== 1'b1) begin errors++; $display("FAIL bin_bout got=%b exp=1", bout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bin_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_handshake;
    int   lat, bc;
    logic moved;
    start_op(8'h05, 8'h03, 1'b0);
    @(negedge clk);
    @(negedge clk);
    i0 = 8'hFF; i1 = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc, moved);
    checks++; if (lat !== 5) begin errors++; $display("FAIL hs_ignored_latency got=%0d exp=5", lat); end
    checks++; if (diff !== 8'h02) begin errors++; $display("FAIL hs_ignored_diff got=%h exp=02", diff); end
    start_op(8'h09, 8'h04, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hs_b2b_busy got=%b exp=1", busy); end
    wait_done(lat, bc, moved);
    checks++; if (moved !== 1'b0) begin errors++; $display("FAIL hs_hold got=%b exp=0", moved); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL hs_b2b_latency got=%0d exp=8", lat); end
    checks++; if (diff !== 8'h05) begin errors++; $display("FAIL hs_b2b_diff got=%h exp=05", diff); end
  endtask

  task automatic test_reset_mid;
    int         lat, bc, seen;
    logic       moved, eb, eo;
    logic [7:0] ed;
    start_op(8'h50, 8'h20, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({busy, done, diff, bout, ovf} !== 12'h000) begin
      errors++;
      $display("FAIL rst_mid_outputs got=%b%b_%h_%b%b exp=00_00_00", busy, done, diff, bout, ovf);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d exp=0", seen); end
    model(8'h3C, 8'hC3, 1'b1, ed, eb, eo);
    start_op(8'h3C, 8'hC3, 1'b1);
    wait_done(lat, bc, moved);
    checks++; if (lat !== 8) begin errors++; $display("FAIL rst_after_latency got=%0d exp=8", lat); end
    checks++; if ({diff, bout, ovf} !== {ed, eb, eo}) begin
      errors++;
      $display("FAIL rst_after_result got=%h/%b/%b exp=%h/%b/%b", diff, bout, ovf, ed, eb, eo);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] a, b, ed;
    logic       c, eb, eo, moved;
    int         lat, bc;
    for (int t = 0; t < 24; t++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      c = 1'($urandom);
      model(a, b, c, ed, eb, eo);
      start_op(a, b, c);
      i0  = 8'($urandom);
      i1  = 8'($urandom);
      bin = 1'($urandom);
      wait_done(lat, bc, moved);
      checks++; if (lat !== 8) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=8", t, lat); end
      checks++; if ({diff, bout, ovf} !== {ed, eb, eo}) begin
        errors++;
        $display("FAIL rnd%0d %h-%h-%b got=%h/%b/%b exp=%h/%b/%b", t, a, b, c,
                 diff, bout, ovf, ed, eb, eo);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    i0    = 8'h00;
    i1    = 8'h00;
    bin   = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_directed;
    test_borrow_in;
    test_handshake;
    @(negedge clk);
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
